l2_mem_responder: RTL and testbench
===================================

# l2_mem_responder

Main-memory responder that sits behind the L2 cache controller and answers its line-granular `mem_r` / `mem_w` requests.
- Latches the request address and write line, then models a fixed access latency followed by a word-serial burst into an internal line array.
- Ends every completed transaction with a one-cycle `mem_ready` pulse.
- On reads, returns the whole line on `mem_rdata`, stable from that pulse until the next read completes.

## Interface
- `WORD_W`, 32, bits per word.
- `LINE_WORDS`, 4, words per cache line (power of two, ≥1).
- `LINES`, 256, lines held in the array (power of two).
- `LATENCY`, 4, access-delay cycles before the burst (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_r`  in  1  line read request; level, held by the cache until `mem_ready`.
- `mem_w`  in  1  line write (write-back) request; level, held until `mem_ready`.
- `mem_addr`  in  32  byte address. Line offset bits are ignored; index = `addr[OFF+IDX-1:OFF]`, where OFF = log2(`WORD_W`/8 * `LINE_WORDS`) and IDX = log2(`LINES`). Upper bits are ignored (aliasing).
- `mem_wdata`  in  `WORD_W*LINE_WORDS`  write line; word 0 in the LSBs.
- `mem_rdata`  out  `WORD_W*LINE_WORDS`  read line; registered.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, BURST, RESP.
- **IDLE**
  - On a clock edge with `mem_w | mem_r`, capture `mem_addr`, the op (write if `mem_w`, else read) and `mem_wdata` into a line buffer.
  - Load the latency counter with `LATENCY-1`, then go to WAIT.
  - If both requests are high, write wins; the cache always writes back before fetching.
- **WAIT**: decrement the counter; at 0, clear the word counter and go to BURST.
- **BURST**: move one word per cycle, word index 0..`LINE_WORDS-1`.
  - Read: array word → read buffer.
  - Write: line buffer word → array.
  - After the last word, go to RESP.
- **RESP**
  - Assert `mem_ready` for exactly this cycle.
  - On a read, load `mem_rdata` from the read buffer at the edge entering RESP.
  - Unconditionally return to IDLE. The request is still high at the RESP edge and must not be re-sampled there.
- **Abort**: if both `mem_r` and `mem_w` are low at an edge in WAIT or BURST, return to IDLE.
  - No `mem_ready` is issued and `mem_rdata` is unchanged.
  - Write words already stored stay stored, because the array is written word-by-word.
- Requests that change op or address mid-transaction are ignored; the captured values are used.
- The array is not reset; its contents are undefined after power-up.

## Timing
- Reset values: `mem_ready`=0, `busy`=0, `mem_rdata`=0, state IDLE, all counters 0.
- An asynchronous reset assertion mid-transaction drops the transaction: no pulse is issued, and partially written words may remain in the array.
- Call the edge that samples the request E0.
  - `mem_ready` is high in the cycle following edge E0+`LATENCY`+`LINE_WORDS`.
  - With the defaults, `mem_ready` is high in cycle 9 and `busy` is high for 9 cycles.
- Back-to-back: the cache raises its next request (e.g. fetch after write-back) in the cycle after the pulse. Since the state is IDLE then, it is sampled at the next edge; there are no lost or duplicate transactions.
- `mem_rdata` holds its value between reads. Writes never alter it.

## Configuration
- `L2MEM_PERF_CNT_EN`
  - Defined: adds outputs `rd_cnt` and `wr_cnt` (32 bits each, reset 0). Each increments in RESP for its op and wraps modulo 2^32. Aborted or reset-dropped transactions are not counted.
  - Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Write line 0xA0 (words 0x11,0x22,0x33,0x44), then read the same address → `mem_ready` 9 cycles after each request edge; `mem_rdata` = {0x44,0x33,0x22,0x11}.
- `mem_w` and `mem_r` both high at address 0x40 → the write executes first; the read, re-sampled after the pulse, returns the written line.
- Model the DWB→DFETCH handshake: deassert `mem_w` and raise `mem_r` the cycle after the pulse → exactly two `mem_ready` pulses, each one cycle wide.
- Drop `mem_r` during WAIT (cycle 2) → `busy` falls next cycle, no `mem_ready`, `mem_rdata` unchanged.
- Assert `rst`=0 during BURST of a write → outputs return to reset values immediately; the next read of the address with `rst`=1 completes normally with a 9-cycle latency.
- With `L2MEM_PERF_CNT_EN`: 3 writes, 2 reads and 1 aborted read → `wr_cnt`=3, `rd_cnt`=2.

Source files
------------

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: main-memory model behind the L2 cache controller.
// It accepts line-granular read/write requests, waits a fixed access latency,
// then moves the line word-serially between a line buffer and the array. It
// finishes with a one-cycle mem_ready pulse. Reads return the full line on
// mem_rdata, which holds its value until the next read completes.
// Optional feature macro: L2MEM_PERF_CNT_EN adds rd_cnt/wr_cnt completion counters.

module l2_mem_responder #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 256,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_r,
  input  logic                         mem_w,
  input  logic [31:0]                  mem_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_wdata,
  output logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
  output logic                         mem_ready,
  output logic                         busy
`ifdef L2MEM_PERF_CNT_EN
  ,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt
`endif
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int OFF    = $clog2(WORD_W / 8 * LINE_WORDS);
  localparam int IDX    = $clog2(LINES);
  localparam int IW     = (IDX > 0) ? IDX : 1;
  localparam int WSEL   = $clog2(LINE_WORDS);
  localparam int WIDX   = (WSEL > 0) ? WSEL : 1;
  localparam int AW     = (IDX + WSEL > 0) ? IDX + WSEL : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                op_wr;
  logic [IW-1:0]       line_q;
  logic [LINE_W-1:0]   wbuf;
  logic [LINE_W-1:0]   rbuf;
  logic [LINE_W-1:0]   rbuf_merge;
  logic [CNT_W-1:0]    lat_cnt;
  logic [WIDX-1:0]     word_idx;

  logic                req;
  logic                capture;
  logic                word_step;
  logic                last_word;
  logic [AW-1:0]       arr_addr;
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   wr_word;

  // The backing store holds whole lines as consecutive words; it is never reset.
  logic [WORD_W-1:0]   mem [LINES*LINE_WORDS];

  assign req       = mem_r | mem_w;
  assign last_word = (32'(word_idx) == LINE_WORDS - 1);
  assign arr_addr  = AW'(32'(line_q) * LINE_WORDS + 32'(word_idx));
  assign rd_word   = mem[arr_addr];
  assign wr_word   = wbuf[32'(word_idx) * WORD_W +: WORD_W];

  // Read buffer with the current burst word slotted in, so the last word can reach mem_rdata on the same edge
  always_comb begin
    rbuf_merge = rbuf;
    rbuf_merge[32'(word_idx) * WORD_W +: WORD_W] = rd_word;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and outputs; dropping both requests in WAIT/BURST aborts, RESP never re-samples
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    word_step = 1'b0;
    mem_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          capture = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (lat_cnt == '0) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          word_step = 1'b1;
          if (last_word) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture, latency/word counters, read buffer and the registered read line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr     <= 1'b0;
      line_q    <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      lat_cnt   <= '0;
      word_idx  <= '0;
      mem_rdata <= '0;
    end else begin
      if (capture) begin
        op_wr   <= mem_w;
        line_q  <= IW'((mem_addr >> OFF) & 32'(LINES - 1));
        wbuf    <= mem_wdata;
        lat_cnt <= CNT_W'(LATENCY - 1);
      end
      if (state_q == WAIT && req) begin
        if (lat_cnt != '0) begin
          lat_cnt <= lat_cnt - CNT_W'(1);
        end else begin
          word_idx <= '0;
        end
      end
      if (word_step) begin
        word_idx <= word_idx + WIDX'(1);
        if (!op_wr) begin
          rbuf <= rbuf_merge;
          if (last_word) begin
            mem_rdata <= rbuf_merge;
          end
        end
      end
    end
  end

  // Word-by-word array write during a write burst, so aborted bursts keep what they already stored
  always_ff @(posedge clk) begin
    if (word_step && op_wr) begin
      mem[arr_addr] <= wr_word;
    end
  end

`ifdef L2MEM_PERF_CNT_EN
  // Completed-transaction counters, bumped only in RESP so aborts and reset-dropped requests never count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state_q == RESP) begin
      if (op_wr) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder: directed scoreboard bench for l2_mem_responder.
// Expected transactions are queued when a request is driven. They are popped
// and compared when mem_ready arrives. Perf counters are checked when
// L2MEM_PERF_CNT_EN is defined.

module tb_l2_mem_responder;

  localparam int LW = 128;

  logic          clk;
  logic          rst;
  logic          mem_r;
  logic          mem_w;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
`ifdef L2MEM_PERF_CNT_EN
  logic [31:0]   rd_cnt;
  logic [31:0]   wr_cnt;
`endif

  typedef struct {
    logic          is_rd;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          sb_q[$];
  logic [LW-1:0] model [256];
  logic [LW-1:0] last_rd;
  int            compared;
  int            failed;
  int            pulse_cnt;
  int            exp_rd;
  int            exp_wr;

  l2_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
`ifdef L2MEM_PERF_CNT_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every mem_ready cycle, sampled mid-cycle
  initial pulse_cnt = 0;
  always @(negedge clk) begin
    if (mem_ready === 1'b1) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and queue what its completion must look like
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [LW-1:0] line);
    exp_t e;
    int   idx;
    idx       = int'((addr >> 4) & 32'hFF);
    mem_w     = wr;
    mem_r     = rd;
    mem_addr  = addr;
    mem_wdata = line;
    if (wr) begin
      model[idx] = line;
      e.is_rd    = 1'b0;
      e.line     = line;
    end else begin
      e.is_rd    = 1'b1;
      e.line     = model[idx];
    end
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for mem_ready, then check latency, data, pulse width and the return to idle
  task automatic awaitResponse(input string tag);
    int   cyc;
    bit   done;
    exp_t e;
    cyc  = 0;
    done = 1'b0;
    while (cyc < 30 && !done) begin
      tick();
      cyc++;
      if (cyc == 1) checkOutput({tag, "_busy_start"}, 128'(busy), 128'(1));
      if (mem_ready === 1'b1) done = 1'b1;
    end
    checkOutput({tag, "_latency"}, 128'(cyc), 128'(9));
    checkOutput({tag, "_busy_at_ready"}, 128'(busy), 128'(1));
    checkOutput({tag, "_sb_nonempty"}, 128'(sb_q.size() > 0), 128'(1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_rd) begin
        checkOutput({tag, "_rdata"}, mem_rdata, e.line);
        last_rd = e.line;
        exp_rd++;
      end else begin
        checkOutput({tag, "_rdata_held"}, mem_rdata, last_rd);
        exp_wr++;
      end
    end
    tick();
    checkOutput({tag, "_pulse_width"}, 128'(mem_ready), 128'(0));
    checkOutput({tag, "_idle_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic [LW-1:0] l1;
    logic [LW-1:0] l2;
    logic [LW-1:0] l3;
    logic [LW-1:0] l4;
    logic [LW-1:0] old_l;
    logic [LW-1:0] new_l;
    int            p0;

    compared  = 0;
    failed    = 0;
    exp_rd    = 0;
    exp_wr    = 0;
    last_rd   = '0;
    rst       = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    l1    = {32'h44, 32'h33, 32'h22, 32'h11};
    l2    = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    l3    = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEEDF00D};
    l4    = {32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A};
    old_l = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
    new_l = {32'h1D1D1D1D, 32'h1C1C1C1C, 32'h1B1B1B1B, 32'h1A1A1A1A};

    $display("[TB] reset state");
    repeat (2) tick();
    checkOutput("rst_ready", 128'(mem_ready), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_rdata", mem_rdata, '0);
    rst = 1'b1;
    tick();

    $display("[TB] write then read line 0xA0");
    applyStimulus(1'b1, 1'b0, 32'h000000A0, l1);
    awaitResponse("wr_a0");
    applyStimulus(1'b0, 1'b1, 32'h000000A0, '0);
    awaitResponse("rd_a0");
    checkOutput("rd_a0_words", mem_rdata, {32'h44, 32'h33, 32'h22, 32'h11});
    mem_r = 1'b0;
    tick();

    $display("[TB] both requests at 0x40, write first then fetch");
    p0 = pulse_cnt;
    applyStimulus(1'b1, 1'b1, 32'h00000040, l2);
    awaitResponse("both_wr");
    applyStimulus(1'b0, 1'b1, 32'h00000040, '0);
    awaitResponse("both_rd");
    mem_r = 1'b0;
    repeat (4) tick();
    checkOutput("handshake_pulses", 128'(pulse_cnt - p0), 128'(2));

    $display("[TB] aliasing and offset bits ignored");
    applyStimulus(1'b1, 1'b0, 32'hFFFF10A0, l3);
    awaitResponse("alias_wr");
    applyStimulus(1'b0, 1'b1, 32'h000000AC, '0);
    awaitResponse("alias_rd");
    applyStimulus(1'b1, 1'b0, 32'h00000FF0, l4);
    awaitResponse("top_wr");
    applyStimulus(1'b0, 1'b1, 32'h00000040, '0);
    awaitResponse("other_rd");
    applyStimulus(1'b0, 1'b1, 32'h00000FF4, '0);
    awaitResponse("top_rd");
    mem_r = 1'b0;
    tick();

    $display("[TB] abort a read during WAIT");
    p0       = pulse_cnt;
    mem_r    = 1'b1;
    mem_addr = 32'h00000040;
    tick();
    tick();
    mem_r = 1'b0;
    tick();
    checkOutput("abort_busy_drop", 128'(busy), 128'(0));
    repeat (12) tick();
    checkOutput("abort_no_pulse", 128'(pulse_cnt - p0), 128'(0));
    checkOutput("abort_rdata_held", mem_rdata, last_rd);

    $display("[TB] reset during a write burst");
    applyStimulus(1'b1, 1'b0, 32'h00000300, old_l);
    awaitResponse("pre_wr");
    mem_w     = 1'b0;
    tick();
    p0        = pulse_cnt;
    mem_w     = 1'b1;
    mem_addr  = 32'h00000300;
    mem_wdata = new_l;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", 128'(mem_ready), 128'(0));
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_rdata", mem_rdata, '0);
    last_rd    = '0;
    exp_rd     = 0;
    exp_wr     = 0;
    model[48]  = {old_l[127:64], new_l[63:0]};
    mem_w      = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    checkOutput("midrst_no_pulse", 128'(pulse_cnt - p0), 128'(0));
    applyStimulus(1'b0, 1'b1, 32'h00000300, '0);
    awaitResponse("post_rst_rd");
    mem_r = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 32'h000000A0, '0);
    awaitResponse("post_rst_rd_a0");
    mem_r = 1'b0;
    tick();

`ifdef L2MEM_PERF_CNT_EN
    $display("[TB] perf counters");
    checkOutput("rd_cnt", 128'(rd_cnt), 128'(exp_rd));
    checkOutput("wr_cnt", 128'(wr_cnt), 128'(exp_wr));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
